// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game blocks: state encoding, colour words
// and bus widths.
package genius_pkg;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned COLOR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP,
        DONE
    } state_t;

    localparam logic [COLOR_W-1:0] COLOR0 = 4'b0001;
    localparam logic [COLOR_W-1:0] COLOR1 = 4'b0010;
    localparam logic [COLOR_W-1:0] COLOR2 = 4'b0100;
    localparam logic [COLOR_W-1:0] COLOR3 = 4'b1000;

endpackage

// File: rtl/seq_player_if.sv
// Playback bus of seq_player: controller handshake, sequence-ROM port and
// LED/status outputs.
interface seq_player_if;
    import genius_pkg::*;

    logic               start;
    logic               abort;
    logic [ADDR_W-1:0]  round;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [COLOR_W-1:0] leds;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, round, rom_data,
        input  rom_addr, leds, busy, done
    );

    modport slave (
        input  start, abort, round, rom_data,
        output rom_addr, leds, busy, done
    );

endinterface

// File: rtl/seq_player_phase_timer.sv
// Phase counter for seq_player: counts up from 0 after each clear and flags the
// last cycle of a phase lasting `limit` cycles.
module phase_timer #(
    parameter int unsigned CNT_W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [CNT_W:0] limit,
    output logic         expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // limit is one bit wider so a phase of exactly 2**CNT_W cycles still fits
    assign expired = ({1'b0, count} == (limit - (CNT_W + 1)'(1)));

endmodule

// File: rtl/seq_player.sv
// Genius round playback: walks the sequence ROM from address 0 to the round
// index, lighting each colour for ON_CYCLES and blanking for OFF_CYCLES.
module seq_player
    import genius_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic    clk,
    input  logic    rst,
    seq_player_if.slave bus
);

    if (ON_CYCLES < 1 || OFF_CYCLES < 1 ||
        ((ON_CYCLES - 1) >> CNT_W) != 0 || ((OFF_CYCLES - 1) >> CNT_W) != 0) begin : g_param_check
        $error("seq_player: CNT_W too narrow for ON_CYCLES/OFF_CYCLES, or a phase length is zero");
    end

    localparam logic [CNT_W:0] ON_LIM  = (CNT_W + 1)'(ON_CYCLES);
    localparam logic [CNT_W:0] OFF_LIM = (CNT_W + 1)'(OFF_CYCLES);

    state_t             state, state_n;
    logic [COLOR_W-1:0] leds_q, leds_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [ADDR_W-1:0]  round_q, round_n;
    logic               last_q, last_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               clear;
    logic               expired;
    logic [CNT_W:0]     limit;

    assign limit = (state == SHOW) ? ON_LIM : OFF_LIM;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .limit   (limit),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            leds_q  <= '0;
            addr_q  <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            leds_q  <= leds_n;
            addr_q  <= addr_n;
            round_q <= round_n;
            last_q  <= last_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        leds_n  = leds_q;
        addr_n  = addr_q;
        round_n = round_q;
        last_n  = last_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        clear   = 1'b0;

        case (state)
            IDLE: begin
                addr_n = '0;
                leds_n = '0;
                busy_n = 1'b0;
                clear  = 1'b1;
                if (bus.start) begin
                    round_n = bus.round;
                    leds_n  = bus.rom_data;
                    last_n  = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (expired) begin
                    state_n = GAP;
                    leds_n  = '0;
                    clear   = 1'b1;
                    // last_q records whether the address advanced, since the
                    // new address alone cannot tell the final step apart
                    if (addr_q != round_q) begin
                        addr_n = addr_q + ADDR_W'(1);
                        last_n = 1'b0;
                    end else begin
                        last_n = 1'b1;
                    end
                end
            end
            GAP: begin
                if (expired) begin
                    clear = 1'b1;
                    if (last_q) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SHOW;
                        leds_n  = bus.rom_data;
                    end
                end
            end
            DONE: begin
                clear   = 1'b1;
                addr_n  = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (bus.abort) begin
            state_n = IDLE;
            leds_n  = '0;
            addr_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            clear   = 1'b1;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.leds     = leds_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: stimulus pushes the expected per-cycle
// outputs of each playback, a negedge monitor pops and compares them.
module tb_seq_player;
    import genius_pkg::*;

    localparam int ON  = 4;
    localparam int OFF = 2;

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] addr;
        logic       busy;
        logic       done;
    } exp_t;

    localparam exp_t IDLE_E = '0;

    logic clk;
    logic rst;
    seq_player_if bus ();

    seq_player #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .CNT_W      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] rom_tab [16];
    assign bus.rom_data = rom_tab[bus.rom_addr];

    exp_t exp_q [$];
    exp_t got, want;
    int   vectors;
    int   miscompares;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{leds: bus.leds, addr: bus.rom_addr, busy: bus.busy, done: bus.done};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL outputs cyc %0d: got leds=%h addr=%0d busy=%b done=%b, expected leds=%h addr=%0d busy=%b done=%b",
                         cyc, got.leds, got.addr, got.busy, got.done,
                         want.leds, want.addr, want.busy, want.done);
            end
        end
    end

    // Expected outputs of an uninterrupted playback, cycle 1 onward.
    function automatic void build(input int r, output exp_t tr [$]);
        exp_t e;
        tr = {};
        for (int k = 0; k <= r; k++) begin
            for (int i = 0; i < ON; i++) begin
                e = '{leds: rom_tab[k], addr: 4'(k), busy: 1'b1, done: 1'b0};
                tr.push_back(e);
            end
            for (int i = 0; i < OFF; i++) begin
                e = '{leds: 4'h0, addr: (k == r) ? 4'(k) : 4'(k + 1), busy: 1'b1, done: 1'b0};
                tr.push_back(e);
            end
        end
        e = '{leds: 4'h0, addr: 4'(r), busy: 1'b0, done: 1'b1};
        tr.push_back(e);
    endfunction

    task automatic idle(input int n, input bit both);
        for (int i = 0; i < n; i++) begin
            bus.start = both;
            bus.abort = both;
            bus.round = 4'($urandom);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            exp_q.push_back(IDLE_E);
        end
    endtask

    // abort_cyc/restart_cyc/rst_cyc: cycle (1-based) during which that input is
    // held high; -1 for none.
    task automatic play(input int r, input int abort_cyc, input int restart_cyc, input int rst_cyc);
        exp_t tr [$];
        bit   cut;
        build(r, tr);
        bus.start = 1'b1;
        bus.round = 4'(r);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.round = 4'($urandom);
        exp_q.push_back(tr[0]);
        for (int c = 1; c < tr.size(); c++) begin
            cut = 1'b0;
            if (c == abort_cyc) begin
                bus.abort = 1'b1;
                cut = 1'b1;
            end
            if (c == rst_cyc) begin
                rst = 1'b1;
                cut = 1'b1;
            end
            if (c == restart_cyc) begin
                bus.start = 1'b1;
                bus.round = 4'($urandom);
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            rst       = 1'b0;
            if (cut) begin
                exp_q.push_back(IDLE_E);
                return;
            end
            exp_q.push_back(tr[c]);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(IDLE_E);
    endtask

    initial begin
        logic [3:0] colors [4];
        int r, ab, rs, len;
        colors = '{COLOR0, COLOR1, COLOR2, COLOR3};
        for (int i = 0; i < 16; i++) begin
            rom_tab[i] = colors[(i * 3 + int'($urandom_range(0, 3))) % 4];
        end
        rom_tab[6] = 4'b0110;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.round   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        idle(10, 1'b0);
        play(0, -1, -1, -1);
        idle(2, 1'b0);
        play(2, -1, -1, -1);
        idle(1, 1'b0);
        play(15, -1, -1, -1);
        play(3, ON + OFF + 3, -1, -1);
        play(1, -1, -1, -1);
        play(4, -1, 8, -1);
        idle(3, 1'b1);
        play(2, -1, 2 * (ON + OFF) + 1 + 3 * 0 + (ON + OFF) + 1, -1);
        play(1, -1, -1, ON + 1);
        idle(2, 1'b0);

        for (int k = 0; k < 10; k++) begin
            r   = int'($urandom_range(0, 15));
            len = (r + 1) * (ON + OFF) + 1;
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : -1;
            rs  = int'($urandom_range(1, len));
            play(r, ab, rs, -1);
            idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
